// File: rtl/dual_port_ram_pipe.sv
// rtl/dual_port_ram_pipe.sv - dual-port RAM with post-reset clear, pipelined read and collision policy
module dual_port_ram_pipe #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int RD_LAT    = 1,
  parameter int COLL_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              coll,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              init_active, run_active;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_in, rd_in, wr_acc, rd_acc, same_addr;
  logic [DATA_W-1:0] rd_word;

  logic              s1_valid_q, s1_err_q, wr_err_q, coll_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The clear pointer walks 0..DEPTH-1 once; RUN is left only through rst.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    init_active = 1'b0;
    run_active  = 1'b0;
    case (state_q)
      S_INIT:  init_active = 1'b1;
      S_RUN:   run_active  = 1'b1;
      default: init_active = 1'b1;
    endcase
  end

  assign init_done = run_active;

  assign wr_in     = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in     = {1'b0, rd_addr} < DEPTH_C;
  assign wr_acc    = run_active && wr_enb;
  assign rd_acc    = run_active && rd_enb;
  assign same_addr = (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (init_active) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc && wr_in) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read-new bypasses the write port; read-old sees the array before this edge's write.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      if (COLL_MODE == 1 && wr_acc && same_addr) rd_word = wr_data;
      else                                       rd_word = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_err_q   <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      s1_err_q   <= rd_acc && !rd_in;
      if (rd_acc) s1_data_q <= rd_word;
      wr_err_q   <= wr_acc && !wr_in;
      coll_q     <= rd_acc && wr_acc && rd_in && same_addr;
    end
  end

  assign wr_err = wr_err_q;
  assign coll   = coll_q;

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q, s2_err_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_err   = s2_err_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_err   = s1_err_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// tb/tb_dual_port_ram_pipe.sv - checks two configurations against a cycle-indexed behavioural model
module tb_dual_port_ram_pipe;

  localparam int NU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enb = 1'b0, rd_enb = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] rd_data [NU];
  logic       rd_valid [NU], rd_err [NU], wr_err [NU], coll [NU], init_done [NU];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Unit 0: defaults. Unit 1: DEPTH=12, two-cycle read, read-new on collision.
  for (genvar g = 0; g < NU; g++) begin : g_u
    localparam int DEP = (g == 0) ? 16 : 12;
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int CM  = (g == 0) ? 0 : 1;

    dual_port_ram_pipe #(
      .DATA_W(8), .ADDR_W(4), .DEPTH(DEP), .RD_LAT(LAT), .COLL_MODE(CM)
    ) u_dut (
      .clk(clk), .rst(rst),
      .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_enb(rd_enb), .rd_addr(rd_addr),
      .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .rd_err(rd_err[g]),
      .wr_err(wr_err[g]), .coll(coll[g]), .init_done(init_done[g])
    );

    int         edges;
    int         en = 0;
    logic [7:0] mmem [16];
    bit         sv [int];
    bit         se [int];
    logic [7:0] sd [int];
    bit         e_valid, e_err, e_wr_err, e_coll, e_done;
    logic [7:0] e_data;

    // Reads are scheduled into the edge index at which their result becomes visible.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        edges = 0;
        sv.delete(); se.delete(); sd.delete();
        e_valid = 0; e_err = 0; e_wr_err = 0; e_coll = 0; e_done = 0; e_data = 8'h00;
      end else begin
        logic [7:0] rv;
        en++;
        e_wr_err = 0;
        e_coll   = 0;
        if (edges < DEP) begin
          mmem[edges] = 8'h00;
          edges++;
        end else begin
          if (rd_enb) begin
            if (int'(rd_addr) >= DEP)                          rv = 8'h00;
            else if (CM == 1 && wr_enb && wr_addr == rd_addr)  rv = wr_data;
            else                                               rv = mmem[rd_addr];
            sv[en + LAT - 1] = 1;
            sd[en + LAT - 1] = rv;
            se[en + LAT - 1] = int'(rd_addr) >= DEP;
          end
          if (wr_enb) begin
            if (int'(wr_addr) < DEP) mmem[wr_addr] = wr_data;
            else                     e_wr_err = 1;
          end
          e_coll = rd_enb && wr_enb && rd_addr == wr_addr && int'(rd_addr) < DEP;
        end
        e_done  = (edges == DEP);
        e_valid = sv.exists(en);
        if (e_valid) begin
          e_data = sd[en];
          e_err  = se[en];
          sv.delete(en); sd.delete(en); se.delete(en);
        end else begin
          e_err = 0;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d rd_valid", g),  rd_valid[g],  rst ? 1'b0  : e_valid);
      chk($sformatf("u%0d rd_err", g),    rd_err[g],    rst ? 1'b0  : e_err);
      chk($sformatf("u%0d rd_data", g),   rd_data[g],   rst ? 8'h00 : e_data);
      chk($sformatf("u%0d wr_err", g),    wr_err[g],    rst ? 1'b0  : e_wr_err);
      chk($sformatf("u%0d coll", g),      coll[g],      rst ? 1'b0  : e_coll);
      chk($sformatf("u%0d init_done", g), init_done[g], rst ? 1'b0  : e_done);
    end
  end

  task automatic drive(input bit we, input int wa, input logic [7:0] wd, input bit re, input int ra);
    wr_enb  = we;
    wr_addr = wa[3:0];
    wr_data = wd;
    rd_enb  = re;
    rd_addr = ra[3:0];
  endtask

  task automatic cyc(input bit we, input int wa, input logic [7:0] wd, input bit re, input int ra);
    @(negedge clk);
    #1;
    drive(we, wa, wd, re, ra);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int n = 1; n <= 40; n++) begin
      after_edge();
      if (n0 == 0 && init_done[0]) n0 = n;
      if (n1 == 0 && init_done[1]) n1 = n;
      if (n == 10) drive(0, 0, 8'h00, 0, 0);
    end
  endtask

  initial begin
    int n0, n1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    drive(1, 5, 8'hFF, 1, 5);
    rst = 1'b0;
    wait_init(n0, n1);
    chk("u0 init edge count", n0, 16);
    chk("u1 init edge count", n1, 12);

    for (int a = 0; a < 16; a++) cyc(0, 0, 8'h00, 1, a);

    cyc(1, 3, 8'hA5, 0, 0);
    cyc(0, 0, 8'h00, 1, 3);
    after_edge();
    drive(0, 0, 8'h00, 0, 0);
    chk("u0 a5 valid", rd_valid[0], 1'b1);
    chk("u0 a5 data", rd_data[0], 8'hA5);
    chk("u1 a5 not yet valid", rd_valid[1], 1'b0);
    after_edge();
    chk("u1 a5 valid", rd_valid[1], 1'b1);
    chk("u1 a5 data", rd_data[1], 8'hA5);

    cyc(1, 7, 8'h11, 0, 0);
    cyc(1, 7, 8'h22, 1, 7);
    after_edge();
    drive(0, 0, 8'h00, 0, 0);
    chk("u0 coll read-old", rd_data[0], 8'h11);
    chk("u0 coll pulse", coll[0], 1'b1);
    chk("u1 coll pulse", coll[1], 1'b1);
    after_edge();
    chk("u1 coll read-new", rd_data[1], 8'h22);

    cyc(1, 13, 8'hFF, 0, 0);
    after_edge();
    drive(0, 0, 8'h00, 0, 0);
    chk("u1 wr_err addr13", wr_err[1], 1'b1);
    chk("u0 no wr_err addr13", wr_err[0], 1'b0);
    cyc(0, 0, 8'h00, 1, 13);
    after_edge();
    drive(0, 0, 8'h00, 0, 0);
    chk("u0 read addr13", rd_data[0], 8'hFF);
    after_edge();
    chk("u1 rd_valid addr13", rd_valid[1], 1'b1);
    chk("u1 rd_err addr13", rd_err[1], 1'b1);
    chk("u1 rd_data addr13", rd_data[1], 8'h00);

    for (int a = 0; a < 16; a++) cyc(1, a, 8'(a * 17 + 3), 0, 0);
    for (int a = 0; a < 16; a++) cyc(1, 15 - a, 8'(a ^ 8'h5A), 1, a);
    for (int a = 0; a < 16; a++) cyc(a % 3 == 0, a, 8'(a * 7), 1, (a * 5) % 16);
    cyc(1, 11, 8'h3C, 1, 11);
    cyc(1, 12, 8'h3D, 1, 12);
    cyc(0, 0, 8'h00, 1, 11);
    cyc(0, 0, 8'h00, 1, 12);
    cyc(0, 0, 8'h00, 0, 0);

    cyc(0, 0, 8'h00, 1, 3);
    after_edge();
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    #1;
    chk("u0 rd_data cleared by rst", rd_data[0], 8'h00);
    chk("u1 no valid after rst", rd_valid[1], 1'b0);
    chk("u1 init_done low in rst", init_done[1], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_init(n0, n1);
    chk("u0 re-init edge count", n0, 16);
    chk("u1 re-init edge count", n1, 12);

    cyc(0, 0, 8'h00, 1, 3);
    after_edge();
    drive(0, 0, 8'h00, 0, 0);
    chk("u0 addr3 cleared", rd_data[0], 8'h00);
    after_edge();
    chk("u1 addr3 cleared valid", rd_valid[1], 1'b1);
    chk("u1 addr3 cleared data", rd_data[1], 8'h00);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
